// File: rtl/m_dmem.sv
// m_dmem: M-stage word-organised data memory with byte/half/word stores and extended loads.
// Optional alignment/range fault checking is compiled in with `define DM_ALIGN_CHECK_EN.
`default_nettype none

module m_dmem #(
   parameter int DEPTH_WORDS = 3072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_enable,
   input  logic        in_we,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_pc,
   output logic [31:0] out_dmout,
   output logic        out_fault
);

   localparam int          IW       = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  OP_W     = 3'd1;
   localparam logic [2:0]  OP_HU    = 3'd2;
   localparam logic [2:0]  OP_HS    = 3'd3;
   localparam logic [2:0]  OP_BU    = 3'd4;
   localparam logic [2:0]  OP_BS    = 3'd5;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [29:0]   word_full;
   logic [IW-1:0] idx;
   logic [1:0]    lane;
   logic [31:0]   rd_word;
   logic [31:0]   wr_word_d;
   logic [15:0]   half_v;
   logic [7:0]    byte_v;
   logic          is_word;
   logic          is_half;
   logic          is_byte;
   logic          op_valid;
   logic          commit;
   logic          w_unused_hi;

   assign word_full   = in_addr[31:2] % 30'(DEPTH_WORDS);
   assign idx         = word_full[IW-1:0];
   assign w_unused_hi = &{1'b0, word_full[29:IW]};
   assign lane        = in_addr[1:0];
   assign rd_word     = mem_q[idx];

   assign is_word  = (in_op == OP_W);
   assign is_half  = (in_op == OP_HU) || (in_op == OP_HS);
   assign is_byte  = (in_op == OP_BU) || (in_op == OP_BS);
   assign op_valid = is_word || is_half || is_byte;

`ifdef DM_ALIGN_CHECK_EN
   assign out_fault = in_enable && (in_op != 3'd0) &&
                      ((is_word && (lane != 2'd0)) ||
                       (is_half && in_addr[0]) ||
                       (in_addr >= 32'(4 * DEPTH_WORDS)));
`else
   assign out_fault = 1'b0;
`endif

   assign commit = in_enable && in_we && op_valid && !out_fault;

   assign half_v = in_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      byte_v = rd_word[7:0];
      case (lane)
         2'd1:    byte_v = rd_word[15:8];
         2'd2:    byte_v = rd_word[23:16];
         2'd3:    byte_v = rd_word[31:24];
         default: byte_v = rd_word[7:0];
      endcase
   end

   always_comb begin
      out_dmout = '0;
      if (in_enable && !in_we && !out_fault) begin
         case (in_op)
            OP_W:    out_dmout = rd_word;
            OP_HU:   out_dmout = {16'h0000, half_v};
            OP_HS:   out_dmout = {{16{half_v[15]}}, half_v};
            OP_BU:   out_dmout = {24'h000000, byte_v};
            OP_BS:   out_dmout = {{24{byte_v[7]}}, byte_v};
            default: out_dmout = '0;
         endcase
      end
   end

   // Merge store data into the current word so untouched lanes are preserved.
   always_comb begin
      wr_word_d = rd_word;
      if (is_word) begin
         wr_word_d = in_wdata;
      end else if (is_half) begin
         if (in_addr[1]) wr_word_d[31:16] = in_wdata[15:0];
         else            wr_word_d[15:0]  = in_wdata[15:0];
      end else if (is_byte) begin
         case (lane)
            2'd1:    wr_word_d[15:8]  = in_wdata[7:0];
            2'd2:    wr_word_d[23:16] = in_wdata[7:0];
            2'd3:    wr_word_d[31:24] = in_wdata[7:0];
            default: wr_word_d[7:0]   = in_wdata[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         mem_q[idx] <= wr_word_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset && commit) begin
         $display("@%08h: *%08h <= %08h", in_pc, 32'({idx, 2'b00}), wr_word_d);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_dmem.sv
// Directed scoreboard bench for m_dmem: expected values are queued at stimulus time and checked on output.
`default_nettype none

module tb_m_dmem;

   logic        clk = 1'b0;
   logic        clk_run = 1'b1;
   logic        reset = 1'b0;
   logic        in_enable = 1'b0;
   logic        in_we = 1'b0;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] out_dmout;
   logic        out_fault;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] sb_q [$];

   m_dmem #(.DEPTH_WORDS(3072)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_enable (in_enable),
      .in_we     (in_we),
      .in_op     (in_op),
      .in_addr   (in_addr),
      .in_wdata  (in_wdata),
      .in_pc     (in_pc),
      .out_dmout (out_dmout),
      .out_fault (out_fault)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
      end else begin
         exp = sb_q.pop_front();
         assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   task automatic bubble();
      in_enable = 1'b1; in_we = 1'b0; in_op = 3'd0; in_wdata = '0;
   endtask

   task automatic store(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic en);
      @(negedge clk);
      in_enable = en; in_we = 1'b1; in_op = op; in_addr = addr; in_wdata = data;
      in_pc = in_pc + 32'd4;
      @(posedge clk);
      #1;
      bubble();
   endtask

   task automatic load(input string tag, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] exp);
      in_enable = 1'b1; in_we = 1'b0; in_op = op; in_addr = addr;
      sb_q.push_back(exp);
      #1;
      compare(tag, out_dmout);
   endtask

   task automatic check_fault(input string tag, input logic exp);
      sb_q.push_back({31'd0, exp});
      #1;
      compare(tag, {31'd0, out_fault});
   endtask

   initial begin
      in_pc = 32'h0000_0400;
      // Reset state
      load("rst_lw0", 3'd1, 32'h0, 32'h0);
      check_fault("rst_fault", 1'b0);
      @(negedge clk);
      reset = 1'b1;
      bubble();

      store(3'd1, 32'h0000, 32'h1234_5678, 1'b1);
      load("lw0", 3'd1, 32'h0000, 32'h1234_5678);

      store(3'd4, 32'h0001, 32'h0000_00AB, 1'b1);
      load("lbu1", 3'd4, 32'h0001, 32'h0000_00AB);
      load("lb1",  3'd5, 32'h0001, 32'hFFFF_FFAB);
      load("lw0_b", 3'd1, 32'h0000, 32'h1234_AB78);

      store(3'd2, 32'h0006, 32'h0000_8001, 1'b1);
      load("lhu6", 3'd2, 32'h0006, 32'h0000_8001);
      load("lh6",  3'd3, 32'h0006, 32'hFFFF_8001);
      load("lw4",  3'd1, 32'h0004, 32'h8001_0000);
      load("lh4",  3'd3, 32'h0004, 32'h0000_0000);

      store(3'd5, 32'h0003, 32'hFFFF_FF7F, 1'b1);
      load("lb3_pos", 3'd5, 32'h0003, 32'h0000_007F);
      load("lw0_c",   3'd1, 32'h0000, 32'h7F34_AB78);
      load("lhu2",    3'd2, 32'h0002, 32'h0000_7F34);

      // Suppressed stores
      store(3'd1, 32'h0010, 32'hDEAD_BEEF, 1'b0);
      store(3'd0, 32'h0010, 32'hDEAD_BEEF, 1'b1);
      load("lw10", 3'd1, 32'h0010, 32'h0);
      load("op6",  3'd6, 32'h0000, 32'h0);
      in_enable = 1'b1; in_we = 1'b1; in_op = 3'd1; in_addr = 32'h0;
      sb_q.push_back(32'h0);
      #1;
      compare("we_rd0", out_dmout);
      in_we = 1'b0; in_enable = 1'b0;
      sb_q.push_back(32'h0);
      #1;
      compare("en0_rd0", out_dmout);
      bubble();

`ifdef DM_ALIGN_CHECK_EN
      in_we = 1'b1; in_op = 3'd1; in_addr = 32'h0002;
      check_fault("flt_sw2", 1'b1);
      store(3'd1, 32'h0002, 32'hAAAA_AAAA, 1'b1);
      store(3'd1, 32'h3000, 32'hBBBB_BBBB, 1'b1);
      load("lw0_nf", 3'd1, 32'h0000, 32'h7F34_AB78);
      load("lh3_flt", 3'd3, 32'h0003, 32'h0);
      check_fault("flt_lh3", 1'b1);
      load("lw3000", 3'd1, 32'h3000, 32'h0);
      check_fault("flt_range", 1'b1);
      bubble();
`else
      load("lw2_mis", 3'd1, 32'h0002, 32'h7F34_AB78);
      check_fault("nflt_mis", 1'b0);
      store(3'd1, 32'h3000, 32'hCAFE_F00D, 1'b1);
      load("lw0_wrap", 3'd1, 32'h0000, 32'hCAFE_F00D);
      check_fault("nflt_rng", 1'b0);
      bubble();
`endif

      // Asynchronous reset with the clock stopped
      store(3'd1, 32'h0014, 32'hA5A5_5A5A, 1'b1);
      load("lw14_pre", 3'd1, 32'h0014, 32'hA5A5_5A5A);
      @(negedge clk);
      clk_run = 1'b0;
      #7;
      reset = 1'b0;
      load("lw0_arst",  3'd1, 32'h0000, 32'h0);
      load("lw14_arst", 3'd1, 32'h0014, 32'h0);
      in_we = 1'b1; in_op = 3'd1; in_addr = 32'h0018; in_wdata = 32'h1111_2222;
      clk_run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bubble();
      reset = 1'b1;
      load("lw18_lost", 3'd1, 32'h0018, 32'h0);
      store(3'd1, 32'h0018, 32'h0000_0055, 1'b1);
      load("lw18_first", 3'd1, 32'h0018, 32'h0000_0055);
      bubble();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
